// File: rtl/hamming_tx_serializer.sv
// Hamming codeword serializer: a small FIFO feeds a start/data/stop framer.
// tx idles high; each frame is 0, codeword bits 0..N-1, then 1, each bit held BIT_TICKS clocks.
module hamming_tx_serializer #(
    parameter int N         = 7,
    parameter int DEPTH     = 4,
    parameter int BIT_TICKS = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:N-1] byte_in,
    input  logic         ready,
    output logic         tx,
    output logic         busy,
    output logic         fifo_full,
    output logic         overflow,
    output logic [7:0]   sent_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [TW-1:0] TICK_LOAD = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ZERO  = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [0:N-1]   shift_q, shift_d;
    logic [0:N-1]   mem_q [DEPTH];
    logic [0:N-1]   mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           full_q, full_d;
    logic           ovf_q, ovf_d;
    logic [7:0]     sent_q, sent_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           push_s;
    logic           pop_s;

    // Framer next-state: bit timing, head-of-FIFO pop and frame counting.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        sent_d  = sent_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != CNT_ZERO) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tick_d  = TICK_LOAD;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_q != TICK_ZERO) begin
                    tick_d = tick_q - TICK_ONE;
                end else begin
                    tick_d  = TICK_LOAD;
                    idx_d   = IDX_ZERO;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick_q != TICK_ZERO) begin
                    tick_d = tick_q - TICK_ONE;
                end else begin
                    tick_d = TICK_LOAD;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            STOP: begin
                if (tick_q != TICK_ZERO) begin
                    tick_d = tick_q - TICK_ONE;
                end else begin
                    sent_d = sent_q + 8'd1;
                    // Chain straight into the next frame so the line never idles between words.
                    if (count_q != CNT_ZERO) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tick_d  = TICK_LOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = TICK_ZERO;
                idx_d   = IDX_ZERO;
            end
        endcase
    end

    // Line level for the coming cycle, taken from the next state so tx comes straight off a flop.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[idx_d];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping; acceptance uses the registered full flag, so a same-edge pop cannot rescue a write.
    always_comb begin
        push_s   = ready & ~full_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (ready & full_q);
        if (push_s) begin
            mem_d[wr_ptr_q] = byte_in;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_FULL);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= TICK_ZERO;
            idx_q    <= IDX_ZERO;
            shift_q  <= {N{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= CNT_ZERO;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            sent_q   <= 8'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {N{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            sent_q   <= sent_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            mem_q    <= mem_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign fifo_full = full_q;
    assign overflow  = ovf_q;
    assign sent_cnt  = sent_q;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Scoreboarded bench: writes queue expected codewords, a negedge monitor checks every tx bit of every frame.
module tb_hamming_tx_serializer;
    localparam int N     = 7;
    localparam int BT    = 2;
    localparam int FRAME = (N + 2) * BT;

    logic         clk = 1'b0;
    logic         reset;
    logic         ready, ready_w;
    logic [0:N-1] byte_in, byte_w;
    logic         tx, busy, fifo_full, overflow;
    logic [7:0]   sent_cnt;
    logic         tx_w, busy_w, full_w, ovf_w;
    logic [7:0]   sent_w;

    int errors = 0;
    int checks = 0;
    logic [0:N-1] exp_q [$];
    int last_run = 0;
    int exp_sent = 0;

    hamming_tx_serializer #(.N(N), .DEPTH(4), .BIT_TICKS(BT)) u_dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .ready(ready),
        .tx(tx), .busy(busy), .fifo_full(fifo_full), .overflow(overflow), .sent_cnt(sent_cnt)
    );

    hamming_tx_serializer #(.N(N), .DEPTH(4), .BIT_TICKS(1)) u_wrap (
        .clk(clk), .reset(reset), .byte_in(byte_w), .ready(ready_w),
        .tx(tx_w), .busy(busy_w), .fifo_full(full_w), .overflow(ovf_w), .sent_cnt(sent_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic write_word(input logic [0:N-1] w, input bit accept);
        byte_in = w;
        ready   = 1'b1;
        if (accept) begin
            exp_q.push_back(w);
            exp_sent++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 2000) check("idle_timeout", 32'(n), 32'd0);
        @(negedge clk);
        #1;
    endtask

    // Monitor: pops one expected word per frame and checks every clock of the line.
    initial begin
        int cyc;
        int run;
        int pos;
        bit have;
        logic [0:N-1] cur;
        logic expbit;
        cyc = 0; run = 0; have = 1'b0; cur = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cyc = 0;
                run = 0;
                have = 1'b0;
                exp_q.delete();
            end else if (busy) begin
                run++;
                if (cyc == 0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        have = 1'b0;
                        $display("FAIL unexpected_frame: got a frame, expected none at %0t", $time);
                    end else begin
                        cur  = exp_q.pop_front();
                        have = 1'b1;
                    end
                end
                if (have) begin
                    pos = cyc / BT;
                    if (pos == 0) expbit = 1'b0;
                    else if (pos == N + 1) expbit = 1'b1;
                    else expbit = cur[pos-1];
                    check("tx_bit", 32'(tx), 32'(expbit));
                end
                cyc = (cyc == FRAME - 1) ? 0 : cyc + 1;
            end else begin
                if (run != 0) last_run = run;
                run = 0;
                if (cyc != 0) check("frame_cut", 32'(cyc), 32'd0);
                cyc = 0;
                check("tx_idle", 32'(tx), 32'd1);
            end
        end
    end

    initial begin
        logic [0:N-1] b2b [4];
        logic [0:N-1] ov [6];
        bit ok;
        int n;
        b2b[0] = 7'h7F; b2b[1] = 7'h00; b2b[2] = 7'h55; b2b[3] = 7'h2A;
        ov[0] = 7'h01; ov[1] = 7'h13; ov[2] = 7'h64; ov[3] = 7'h3C; ov[4] = 7'h7E; ov[5] = 7'h40;
        reset = 1'b1; ready = 1'b0; ready_w = 1'b0; byte_in = '0; byte_w = 7'b1010101;

        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_sent", 32'(sent_cnt), 32'd0);
        @(posedge clk); #1;

        // Single frame with latency
        write_word(7'b1100110, 1'b1);
        ready = 1'b0;
        @(negedge clk);
        check("lat_e0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("lat_e1_busy", 32'(busy), 32'd1);
        check("lat_e1_tx", 32'(tx), 32'd0);
        wait_idle();
        check("single_run", 32'(last_run), 32'd18);
        check("single_sent", 32'(sent_cnt), 32'd1);
        check("single_tx_after", 32'(tx), 32'd1);

        // Back-to-back frames
        for (int i = 0; i < 4; i++) write_word(b2b[i], 1'b1);
        ready = 1'b0;
        wait_idle();
        check("b2b_run", 32'(last_run), 32'd72);
        check("b2b_sent", 32'(sent_cnt), 32'd5);
        check("b2b_ovf", 32'(overflow), 32'd0);

        // Overflow: fifth write fills the FIFO, sixth is dropped
        for (int i = 0; i < 4; i++) write_word(ov[i], 1'b1);
        check("ovf_full_after4", 32'(fifo_full), 32'd0);
        write_word(ov[4], 1'b1);
        check("ovf_full_after5", 32'(fifo_full), 32'd1);
        write_word(ov[5], 1'b0);
        ready = 1'b0;
        check("ovf_flag", 32'(overflow), 32'd1);
        wait_idle();
        check("ovf_run", 32'(last_run), 32'd90);
        check("ovf_sent", 32'(sent_cnt), 32'd10);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_full_drained", 32'(fifo_full), 32'd0);

        // Reset during DATA bit 3 of the first of three queued frames
        for (int i = 0; i < 3; i++) write_word(b2b[i], 1'b1);
        ready = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        check("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_sent = 0;
        repeat (60) @(posedge clk);
        #2;
        check("mid_sent", 32'(sent_cnt), 32'd0);
        check("mid_busy_after", 32'(busy), 32'd0);
        check("mid_ovf_cleared", 32'(overflow), 32'd0);

        // Counter wrap on the BIT_TICKS=1 instance
        for (int f = 1; f <= 256; f++) begin
            ready_w = 1'b1;
            @(posedge clk); #1;
            ready_w = 1'b0;
            ok = 1'b0;
            n = 0;
            while (!ok && n < 40) begin
                @(posedge clk); #1;
                n++;
                if (busy_w) ok = 1'b1;
            end
            while (ok && busy_w && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            if (!ok || n >= 40) begin
                check("wrap_timeout", 32'(n), 32'd0);
                break;
            end
            check("wrap_sent", 32'(sent_w), 32'(f % 256));
            if (f == 255) check("wrap_255", 32'(sent_w), 32'd255);
            if (f == 256) check("wrap_0", 32'(sent_w), 32'd0);
        end
        check("wrap_ovf", 32'(ovf_w), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hamming_tx_serializer.md
Name: hamming_tx_serializer

Overview:
- Sits directly downstream of the Hamming(7,4) encoder and converts its parallel codewords into a framed serial bitstream for the channel.
- Buffers codewords in a small FIFO so the encoder can strobe words faster than one frame time.
- Each frame is 1 start bit (0), N codeword bits sent index 0 first, then 1 stop bit (1).
- A matching deserializer in front of the decoder is a separate block.

Parameters:
- N, 7, codeword width in bits (matches encoder byte_out).
- DEPTH, 4, FIFO depth in words; power of 2, minimum 2.
- BIT_TICKS, 2, clocks each serial bit is held; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- byte_in  in  [0:N-1]  codeword from the encoder; bit 0 is transmitted first.
- ready  in  1  write strobe from the encoder; byte_in is valid in any cycle where ready=1.
- tx  out  1  serial line; idles high.
- busy  out  1  high whenever a frame is in progress (state != IDLE).
- fifo_full  out  1  registered; high when the FIFO holds DEPTH words.
- overflow  out  1  sticky; set when a word is dropped.
- sent_cnt  out  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset (async, any time including mid-frame):
  - tx=1, busy=0, fifo_full=0, overflow=0, sent_cnt=0.
  - FIFO pointers and count cleared; FSM returns to IDLE; bit and tick counters cleared.
  - Words buffered before reset are never sent.
- FIFO write:
  - On a rising edge with ready=1 and fifo_full=0, byte_in is pushed.
  - If ready=1 and fifo_full=1, the word is dropped and overflow is set. This applies even if a pop occurs on the same edge (fifo_full is the registered value).
  - overflow clears only on reset.
- FIFO pointers wrap modulo DEPTH. Count is held in a log2(DEPTH)+1 bit register. fifo_full = (count==DEPTH).
- A simultaneous push and pop leaves count unchanged.
- FSM states:
  - IDLE: tx=1. If count!=0, pop the head word into the shift register, load the tick counter, and go to START.
  - START: tx=0 for BIT_TICKS clocks, then go to DATA with bit index 0.
  - DATA: tx=shift[index], each bit held BIT_TICKS clocks. Go to STOP after index N-1.
  - STOP: tx=1 for BIT_TICKS clocks. On the last tick, sent_cnt increments. Then:
    - if count!=0, pop the next word and go directly to START (no idle gap between frames);
    - otherwise go to IDLE.
- tx is a registered output and is glitch-free.
- Latency: a word sampled on edge E0 into an empty FIFO with the FSM in IDLE is popped on E1; tx falls after E1.
- Frame length is (N+2)*BIT_TICKS clocks; busy stays high for that whole duration.
- Back-to-back frames keep busy high continuously.
- The word in the shift register is unaffected by later FIFO writes.

Test Plan:
- Reset check: hold reset for 2 cycles, then release with ready=0 -> tx=1, busy=0, fifo_full=0, overflow=0, sent_cnt=0; outputs stay there indefinitely.
- Single frame: write byte_in=7'b1100110 (bit0=1) once -> one clock later tx plays 0,1,1,0,0,1,1,0,1, each held 2 clocks; busy high for exactly 18 clocks; sent_cnt=1; tx=1 afterwards.
- Back-to-back: 4 writes on consecutive cycles (0x7F, 0x00, 0x55, 0x2A) -> 4 contiguous frames, 72 clocks of busy with no idle gap; bits match the words in order; sent_cnt=4; overflow=0.
- Overflow: 6 writes on consecutive cycles (DEPTH=4) -> fifo_full rises after the 5th write; the 6th word is dropped and overflow=1; exactly 5 frames are sent; overflow remains 1 until reset.
- Reset mid-frame: queue 3 words, then assert reset during DATA bit 3 of frame 1 -> tx=1 and busy=0 immediately (asynchronous); after release, no further frames are sent and sent_cnt=0.
- Counter wrap: send 256 frames with BIT_TICKS=1 -> sent_cnt reads 255 after the 255th frame and 0 after the 256th.
